// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell plus a borrow flop.
// Ports: clk, rst (sync, active high), start/a/b in; busy/done/diff/borrow_out out.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nx;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             x;
  logic             y;
  logic             d;
  logic             bo;
  logic             last;

  // full-subtractor cell on the current LSBs
  always_comb begin
    x      = a_sr[0];
    y      = b_sr[0];
    d      = x ^ y ^ borrow;
    bo     = (~x & y) | (~(x ^ y) & borrow);
    res_nx = {d, res_sr[WIDTH-1:1]};
    last   = (cnt == LAST);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      borrow     <= 1'b0;
      cnt        <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      done  <= (state_nx == DONE);
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nx;
          borrow <= bo;
          // result lands in diff on the edge that enters DONE,
          // so it is valid while done is high
          if (last) begin
            diff       <= res_nx;
            borrow_out <= bo;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
